// File: rtl/cast_rr_arbiter.sv
// Round-robin arbiter feeding a shared two-stage signed fixed-point cast pipeline.
// Optional feature: define CAST_RR_ROUND_EN for round-half-up instead of truncation.
module cast_rr_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DIN_WIDTH  = 16,
  parameter int unsigned DIN_INT    = 8,
  parameter int unsigned DOUT_WIDTH = 8,
  parameter int unsigned DOUT_INT   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*DIN_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic [DOUT_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  output logic [ID_WIDTH-1:0]          dout_id,
  output logic                         dout_sat
);

  localparam int unsigned FracIn  = DIN_WIDTH - DIN_INT;
  localparam int unsigned FracOut = DOUT_WIDTH - DOUT_INT;
  localparam int unsigned Shift   = FracIn - FracOut;
  // One guard bit so the rounding add can never wrap.
  localparam int unsigned ExtW    = DIN_WIDTH + 1;

  localparam logic signed [ExtW-1:0] SatMax =
    {{(ExtW - DOUT_WIDTH + 1){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ExtW-1:0] SatMin =
    {{(ExtW - DOUT_WIDTH + 1){1'b1}}, {(DOUT_WIDTH - 1){1'b0}}};

`ifdef CAST_RR_ROUND_EN
  localparam int unsigned HalfPos = (Shift > 0) ? Shift - 1 : 0;
  localparam logic signed [ExtW-1:0] HalfLsb =
    (Shift > 0) ? (ExtW'(1) << HalfPos) : '0;
`endif

  // Arbitration
  logic [ID_WIDTH-1:0]  r_ptr;
  logic [ID_WIDTH-1:0]  w_idx;
  logic [ID_WIDTH-1:0]  w_gnt_id;
  logic [ID_WIDTH-1:0]  w_ptr_nxt;
  logic                 w_gnt_any;
  logic [N_REQ-1:0]     w_grant;
  logic [DIN_WIDTH-1:0] w_gnt_data;

  always_comb begin
    w_grant   = '0;
    w_gnt_id  = '0;
    w_gnt_any = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_idx = ID_WIDTH'((32'(r_ptr) + 32'(k)) % N_REQ);
      if (!w_gnt_any && req_valid[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_gnt_id       = w_idx;
        w_gnt_any      = 1'b1;
      end
    end
    // Reset blocks every grant so nothing enters the pipe while it is being cleared.
    if (rst) begin
      w_grant   = '0;
      w_gnt_any = 1'b0;
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_grant[i]) begin
        w_gnt_data = req_data[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_id == ID_WIDTH'(N_REQ - 1)) ? '0 : w_gnt_id + ID_WIDTH'(1);
  assign req_ready = w_grant;

  // Stage 1: capture the granted word
  logic                 r_s1_valid;
  logic [DIN_WIDTH-1:0] r_s1_data;
  logic [ID_WIDTH-1:0]  r_s1_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_id    <= '0;
      r_ptr      <= '0;
    end else begin
      r_s1_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_s1_data <= w_gnt_data;
        r_s1_id   <= w_gnt_id;
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  // Cast: optional rounding, arithmetic shift (floor), then clamp.
  logic signed [ExtW-1:0]   w_ext;
  logic signed [ExtW-1:0]   w_rnd;
  logic signed [ExtW-1:0]   w_shr;
  logic                     w_sat_hi;
  logic                     w_sat_lo;
  logic [DOUT_WIDTH-1:0]    w_cast;

  always_comb begin
    w_ext = {r_s1_data[DIN_WIDTH-1], r_s1_data};
`ifdef CAST_RR_ROUND_EN
    w_rnd = w_ext + HalfLsb;
`else
    w_rnd = w_ext;
`endif
    w_shr    = w_rnd >>> Shift;
    w_sat_hi = (w_shr > SatMax);
    w_sat_lo = (w_shr < SatMin);
    if (w_sat_hi) begin
      w_cast = {1'b0, {(DOUT_WIDTH - 1){1'b1}}};
    end else if (w_sat_lo) begin
      w_cast = {1'b1, {(DOUT_WIDTH - 1){1'b0}}};
    end else begin
      w_cast = w_shr[DOUT_WIDTH-1:0];
    end
  end

  // Stage 2: registered result, held while idle
  logic                  r_dout_valid;
  logic [DOUT_WIDTH-1:0] r_dout;
  logic [ID_WIDTH-1:0]   r_dout_id;
  logic                  r_dout_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_dout_id    <= '0;
      r_dout_sat   <= 1'b0;
    end else begin
      r_dout_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout     <= w_cast;
        r_dout_id  <= r_s1_id;
        r_dout_sat <= w_sat_hi | w_sat_lo;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_id    = r_dout_id;
  assign dout_sat   = r_dout_sat;

endmodule

// File: tb/tb_cast_rr_arbiter.sv
// Directed bench for cast_rr_arbiter (Q8.8 -> Q4.4, 4 requesters) with an output scoreboard.
module tb_cast_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic [1:0]  dout_id;
  logic        dout_sat;

  cast_rr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_id    (dout_id),
    .dout_sat   (dout_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] dout;
    logic [1:0] id;
    logic       sat;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [15:0] lane_data[4];
  logic [8:0]  lane_exp[4];
  logic [7:0]  last_dout;
  logic [1:0]  last_id;
  logic        last_sat;

  // Reference: floor(x / 16) (optionally of x + 8), then clamp to [-128, 127].
  function automatic logic [8:0] cast_model(input logic [15:0] d);
    int v;
    v = int'($signed(d));
`ifdef CAST_RR_ROUND_EN
    v = v + 8;
`endif
    v = v >>> 4;
    if (v > 127)  return {1'b1, 8'h7F};
    if (v < -128) return {1'b1, 8'h80};
    return {1'b0, v[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_lane(input int i, input logic [15:0] d);
    lane_data[i] = d;
    lane_exp[i]  = cast_model(d);
  endtask

  task automatic set_lane_exp(input int i, input logic [15:0] d, input logic [7:0] o,
                              input logic s);
    lane_data[i] = d;
    lane_exp[i]  = {s, o};
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("latency", 32'(cyc), 32'(e.due));
      check("dout_valid", 32'(dout_valid), 32'd1);
      check("dout", 32'(dout), 32'(e.dout));
      check("dout_id", 32'(dout_id), 32'(e.id));
      check("dout_sat", 32'(dout_sat), 32'(e.sat));
      last_dout = e.dout;
      last_id   = e.id;
      last_sat  = e.sat;
    end else begin
      check("idle_valid", 32'(dout_valid), 32'd0);
      check("hold_dout", 32'(dout), 32'(last_dout));
      check("hold_id", 32'(dout_id), 32'(last_id));
      check("hold_sat", 32'(dout_sat), 32'(last_sat));
    end
  endtask

  // One cycle: drive after the edge, sample on the falling edge, g = expected grant (-1 none).
  task automatic step(input logic [3:0] v, input int g);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = v;
    req_data  = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};
    @(negedge clk);
    cyc++;
    check_out();
    check("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    if (g >= 0) begin
      e.due  = cyc + 2;
      e.dout = lane_exp[g][7:0];
      e.id   = g[1:0];
      e.sat  = lane_exp[g][8];
      q.push_back(e);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = '1;
    last_dout = '0;
    last_id   = '0;
    last_sat  = 1'b0;
    set_lane(0, 16'h0123);
    set_lane(1, 16'hFEDC);
    set_lane(2, 16'h0456);
    set_lane(3, 16'h8000);

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_id", 32'(dout_id), 32'd0);
    check("rst_sat", 32'(dout_sat), 32'd0);
    req_valid = 4'h0;
    rst       = 1'b0;

    // All requesters busy: strict rotation starting at 0
    step(4'hF, 0);
    step(4'hF, 1);
    step(4'hF, 2);
    step(4'hF, 3);
    step(4'hF, 0);
    step(4'hF, 1);
    // Pointer now 2; walk it to 3 and exercise the wrap
    step(4'b0100, 2);
    step(4'b0000, -1);
    step(4'b0100, 2);
    step(4'b1001, 3);

    // Cast corners through lane 0
    set_lane_exp(0, 16'h0180, 8'h18, 1'b0);
    step(4'b0001, 0);
    set_lane_exp(0, 16'h0800, 8'h7F, 1'b1);
    step(4'b0001, 0);
    set_lane_exp(0, 16'hF800, 8'h80, 1'b0);
    step(4'b0001, 0);
`ifdef CAST_RR_ROUND_EN
    set_lane_exp(0, 16'hF7FF, 8'h80, 1'b0);
    step(4'b0001, 0);
    set_lane_exp(0, 16'h0018, 8'h02, 1'b0);
    step(4'b0001, 0);
    set_lane_exp(0, 16'h07F8, 8'h7F, 1'b1);
    step(4'b0001, 0);
`else
    set_lane_exp(0, 16'hF7FF, 8'h80, 1'b1);
    step(4'b0001, 0);
    set_lane_exp(0, 16'h0018, 8'h01, 1'b0);
    step(4'b0001, 0);
    set_lane_exp(0, 16'h07F8, 8'h7F, 1'b0);
    step(4'b0001, 0);
`endif
    repeat (3) step(4'h0, -1);

    // Mid-cycle reset with two items in flight
    set_lane(0, 16'h0123);
    set_lane(1, 16'hFEDC);
    step(4'b0011, 1);
    step(4'b0011, 0);
    @(posedge clk);
    #1;
    req_valid = 4'h0;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_id", 32'(dout_id), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    #1;
    rst = 1'b0;
    cyc++;
    q.delete();
    last_dout = '0;
    last_id   = '0;
    last_sat  = 1'b0;

    repeat (3) step(4'h0, -1);
    step(4'hF, 0);
    step(4'hF, 1);
    for (int i = 0; i < 6 && q.size() > 0; i++) step(4'h0, -1);
    check("drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cast_rr_arbiter.md
CAST_RR_ARBITER -- requirements
Module: cast_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one cast pipeline.
REQ-002 The block SHALL have parameter ID_WIDTH, default 2, giving the requester-index width, with 2^ID_WIDTH >= N_REQ.
REQ-003 The block SHALL have parameters DIN_WIDTH, DIN_INT, DOUT_WIDTH, DOUT_INT, defaults 16, 8, 8, 4, giving signed fixed-point total and integer widths.
REQ-004 The block SHALL restrict parameters to DIN_INT >= DOUT_INT and (DIN_WIDTH-DIN_INT) >= (DOUT_WIDTH-DOUT_INT).
REQ-005 The block SHALL have the following ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester data valid
- req_data  in  N_REQ*DIN_WIDTH  requester i occupies bits [i*DIN_WIDTH +: DIN_WIDTH]
- req_ready  out  N_REQ  one-hot grant, combinational
- dout  out  DOUT_WIDTH  cast result
- dout_valid  out  1  dout/dout_id/dout_sat valid
- dout_id  out  ID_WIDTH  index of the originating requester
- dout_sat  out  1  result was saturated

Function
REQ-006 The block SHALL assert req_ready[i] for at most one i per cycle, and only while req_valid[i]=1.
REQ-007 The block SHALL grant round-robin: the search starts at pointer p, proceeds p, p+1, ..., N_REQ-1, 0, and the first valid requester wins.
REQ-008 The block SHALL load p with (i+1) mod N_REQ after a grant to i, and SHALL leave p unchanged in a cycle with no grant.
REQ-009 The block SHALL treat a transfer as req_valid[i]&req_ready[i]; the output side has no backpressure, and one transfer may occur per cycle.
REQ-010 The block SHALL use 2-stage pipelining:
- Stage 1 registers data, id and valid.
- Stage 2 registers dout, dout_id, dout_sat and dout_valid.
- A transfer in cycle n produces dout_valid=1 in cycle n+2.
REQ-011 The block SHALL interpret input as two's complement with DIN_WIDTH-DIN_INT fraction bits.
REQ-012 The block SHALL produce output with DOUT_WIDTH-DOUT_INT fraction bits.
REQ-013 The block SHALL drop excess fraction LSBs by truncation (toward -infinity) when rounding is compiled out.
REQ-014 The block SHALL saturate any value above the output maximum to 0 followed by all ones, with dout_sat=1.
REQ-015 The block SHALL saturate any value below the output minimum to 1 followed by all zeros, with dout_sat=1.
REQ-016 The block SHALL output representable values exactly, including the exact output minimum, with dout_sat=0.
REQ-017 The block SHALL hold dout, dout_id and dout_sat at their last values while dout_valid=0.

Reset
REQ-018 The block SHALL, on rst=1 and independent of clk, clear dout, dout_id, dout_sat, dout_valid, all stage-1 registers and p to 0.
REQ-019 The block SHALL hold req_ready at all zeros while rst=1.
REQ-020 The block SHALL discard in-flight items on reset and SHALL NOT emit them after rst deasserts.

Configuration
REQ-021 The block SHALL use macro CAST_RR_ROUND_EN to select the rounding mode.
- Defined: add half an output LSB before dropping fraction bits (round half up), then apply saturation, with the round-induced overflow saturating and setting dout_sat.
- Undefined: truncation per REQ-013, with no rounding adder synthesized.
- Latency is identical in both cases.

Verification (defaults, Q8.8 -> Q4.4)
REQ-022 The bench SHALL hold all four req_valid continuously from p=0 -> grants 0,1,2,3,0,1, with dout_id following the same order two cycles later and dout_valid continuously high.
REQ-023 The bench SHALL apply only req_valid[2] after p=3 -> grant 2, then p=3; next cycle with req_valid[0]&req_valid[3] -> grant 3.
REQ-024 The bench SHALL apply casts:
- 0x0180 -> 0x18, sat=0
- 0x0800 -> 0x7F, sat=1
- 0xF800 -> 0x80, sat=0
- 0xF7FF -> 0x80, sat=1
REQ-025 The bench SHALL apply 0x0018 -> 0x01 without CAST_RR_ROUND_EN and 0x02 with it, and 0x07F8 -> 0x7F with sat=0 without the macro and sat=1 with it.
REQ-026 The bench SHALL pulse rst mid-cycle with two items in flight -> dout_valid=0 immediately, no stale outputs afterwards, and the first grant after release goes to requester 0.
